roi_pixel_sink: RTL

Receiving end of the radar ROI pixel protocol. It latches the window request (two corners plus channel) on data_start and collects the raster pixel stream returned on pixel_out, closed by data_end. For each window it reports pixel count, sum and peak value with peak location, and flags length and timeout errors. It sits on the consumer side of the ROI pixel generator and feeds downstream detection logic.

---
 rtl/roi_pixel_sink.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/roi_pixel_sink.sv
// ROI pixel sink: latches a window request, collects its raster pixel
// stream and reports count, sum, peak location and protocol errors.
module roi_pixel_sink #(
    parameter int ROW_W     = 8,
    parameter int COL_W     = 8,
    parameter int CH_W      = 4,
    parameter int PIX_W     = 16,
    parameter int SUM_W     = 32,
    parameter int START_LAT = 2,
    parameter int SLACK     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROW_W-1:0]       row_idx1,
    input  logic [COL_W-1:0]       col_idx1,
    input  logic [ROW_W-1:0]       row_idx2,
    input  logic [COL_W-1:0]       col_idx2,
    input  logic [CH_W-1:0]        channel_num,
    input  logic                   data_start,
    input  logic                   data_end,
    input  logic [PIX_W-1:0]       pixel_out,
    output logic                   busy,
    output logic                   done,
    output logic [CH_W-1:0]        res_ch,
    output logic [ROW_W+COL_W-1:0] pix_count,
    output logic [SUM_W-1:0]       pix_sum,
    output logic [PIX_W-1:0]       peak_val,
    output logic [ROW_W-1:0]       peak_row,
    output logic [COL_W-1:0]       peak_col,
    output logic                   err_len,
    output logic                   err_range,
    output logic                   err_timeout
);
    localparam int CNT_W = ROW_W + COL_W;
    localparam int LAT_W = $clog2(START_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;
    state_t state, state_nxt;

    logic [ROW_W-1:0] r2_q, cur_row;
    logic [COL_W-1:0] c1_q, c2_q, cur_col;
    logic [CNT_W-1:0] exp_cnt, exp_req, cnt_nxt;
    logic [CNT_W:0]   lim;
    logic [LAT_W-1:0] lat_cnt;
    logic             range_bad, at_limit, last_pos, new_peak;

    always_comb begin
        range_bad = (row_idx2 < row_idx1) || (col_idx2 < col_idx1);
        exp_req   = (CNT_W'(row_idx2) - CNT_W'(row_idx1) + CNT_W'(1))
                  * (CNT_W'(col_idx2) - CNT_W'(col_idx1) + CNT_W'(1));
        cnt_nxt   = pix_count + CNT_W'(1);
        lim       = {1'b0, exp_cnt} + (CNT_W+1)'(SLACK);
        at_limit  = ({1'b0, cnt_nxt} == lim);
        last_pos  = (cur_row == r2_q) && (cur_col == c2_q);
        new_peak  = (pix_count == '0) || (pixel_out > peak_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (data_start) begin
                    if (range_bad)           state_nxt = DONE;
                    else if (START_LAT == 1) state_nxt = STREAM;
                    else                     state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_end)                   state_nxt = DONE;
                else if (lat_cnt <= LAT_W'(1))  state_nxt = STREAM;
            end
            STREAM: begin
                if (data_end || at_limit) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == WAIT) || (state == STREAM);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            cur_row     <= '0;
            cur_col     <= '0;
            exp_cnt     <= '0;
            lat_cnt     <= '0;
            res_ch      <= '0;
            pix_count   <= '0;
            pix_sum     <= '0;
            peak_val    <= '0;
            peak_row    <= '0;
            peak_col    <= '0;
            err_len     <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_start) begin
                        r2_q        <= row_idx2;
                        c1_q        <= col_idx1;
                        c2_q        <= col_idx2;
                        cur_row     <= row_idx1;
                        cur_col     <= col_idx1;
                        exp_cnt     <= exp_req;
                        lat_cnt     <= LAT_W'(START_LAT - 1);
                        res_ch      <= channel_num;
                        pix_count   <= '0;
                        pix_sum     <= '0;
                        peak_val    <= '0;
                        peak_row    <= '0;
                        peak_col    <= '0;
                        err_len     <= 1'b0;
                        err_range   <= range_bad;
                        err_timeout <= 1'b0;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (data_end || data_start) err_len <= 1'b1;
                end
                STREAM: begin
                    pix_count <= cnt_nxt;
                    pix_sum   <= pix_sum + SUM_W'(pixel_out);
                    if (new_peak) begin
                        peak_val <= pixel_out;
                        peak_row <= cur_row;
                        peak_col <= cur_col;
                    end
                    // Position sticks at the last corner once the window is full
                    if (!last_pos) begin
                        if (cur_col == c2_q) begin
                            cur_col <= c1_q;
                            cur_row <= cur_row + ROW_W'(1);
                        end else begin
                            cur_col <= cur_col + COL_W'(1);
                        end
                    end
                    if (data_start
                        || (data_end && (cnt_nxt != exp_cnt))
                        || (!data_end && (cnt_nxt >= exp_cnt)))
                        err_len <= 1'b1;
                    if (at_limit && !data_end) err_timeout <= 1'b1;
                end
                DONE: ;
                default: ;
            endcase
        end
    end
endmodule
